// File: rtl/game_flow.sv
// game_flow: frame-rate match sequencer between the score stage and ball logic.
// Every timer counts frames of the slow clock. Outputs are all registered.
// Optional feature: define GAME_FLOW_AUTO_RESTART_EN to return OVER -> IDLE
// automatically after OVER_TIMEOUT frames.
module game_flow #(
  parameter int SERVE_DELAY  = 30,
  parameter int POINT_PAUSE  = 45,
  parameter int BLINK_PERIOD = 15,
  parameter int DEBOUNCE_LEN = 3,
  parameter int OVER_TIMEOUT = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       score_left,
  input  logic       score_right,
  input  logic       game_over,
  output logic       ball_enable,
  output logic       serve,
  output logic       serve_dir,
  output logic       score_clear,
  output logic       blink,
  output logic [2:0] state
);

  localparam int M01  = (SERVE_DELAY > POINT_PAUSE) ? SERVE_DELAY : POINT_PAUSE;
  localparam int M23  = (BLINK_PERIOD > DEBOUNCE_LEN) ? BLINK_PERIOD : DEBOUNCE_LEN;
  localparam int M03  = (M01 > M23) ? M01 : M23;
  localparam int MAXP = (M03 > OVER_TIMEOUT) ? M03 : OVER_TIMEOUT;
  localparam int TW   = $clog2(MAXP) + 1;
  localparam int DW   = $clog2(DEBOUNCE_LEN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [TW-1:0] SD_L  = TW'(SERVE_DELAY - 1);
  localparam logic [TW-1:0] PP_L  = TW'(POINT_PAUSE - 1);
  localparam logic [TW-1:0] BP_L  = TW'(BLINK_PERIOD - 1);
  localparam logic [DW-1:0] DEB_C = DW'(DEBOUNCE_LEN);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          dir_q, dir_d;
  logic          serve_q, serve_d;
  logic          clr_q, clr_d;
  logic          blink_q, blink_d;
  logic          be_q, be_d;

`ifdef GAME_FLOW_AUTO_RESTART_EN
  localparam int            OW   = $clog2(OVER_TIMEOUT) + 1;
  localparam logic [OW-1:0] OT_L = OW'(OVER_TIMEOUT - 1);
  logic [OW-1:0] ot_q, ot_d;
`endif

  // Debounce: saturating run-length of start_btn; one press per hold
  always_comb begin
    cnt_d = '0;
    if (start_btn) cnt_d = (cnt_q == DEB_C) ? cnt_q : cnt_q + 1'b1;
    press_d = (cnt_d == DEB_C) && (cnt_q != DEB_C);
  end

  // State register and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      dir_q   <= 1'b1;
      serve_q <= 1'b0;
      clr_q   <= 1'b0;
      blink_q <= 1'b0;
      be_q    <= 1'b0;
`ifdef GAME_FLOW_AUTO_RESTART_EN
      ot_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      dir_q   <= dir_d;
      serve_q <= serve_d;
      clr_q   <= clr_d;
      blink_q <= blink_d;
      be_q    <= be_d;
`ifdef GAME_FLOW_AUTO_RESTART_EN
      ot_q    <= ot_d;
`endif
    end
  end

  // Next state, timer reloads and the transition-driven pulses
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    serve_d = 1'b0;
    clr_d   = 1'b0;
`ifdef GAME_FLOW_AUTO_RESTART_EN
    ot_d    = ot_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (press_q) begin
          state_d = S_SERVE;
          timer_d = SD_L;
          serve_d = 1'b1;
          clr_d   = 1'b1;
        end
      end
      S_SERVE: begin
        if (timer_q == '0) state_d = S_PLAY;
        else               timer_d = timer_q - 1'b1;
      end
      S_PLAY: begin
        if (score_left || score_right) begin
          // Left wins a same-cycle tie; next serve heads toward the scorer
          state_d = S_POINT;
          dir_d   = !score_left;
          timer_d = PP_L;
        end else if (game_over) begin
          state_d = S_OVER;
          timer_d = BP_L;
`ifdef GAME_FLOW_AUTO_RESTART_EN
          ot_d    = OT_L;
`endif
        end
      end
      S_POINT: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (game_over) begin
          state_d = S_OVER;
          timer_d = BP_L;
`ifdef GAME_FLOW_AUTO_RESTART_EN
          ot_d    = OT_L;
`endif
        end else begin
          state_d = S_SERVE;
          timer_d = SD_L;
          serve_d = 1'b1;
        end
      end
      S_OVER: begin
        // Timer doubles as the blink half-period counter while in OVER
        timer_d = (timer_q == '0) ? BP_L : timer_q - 1'b1;
`ifdef GAME_FLOW_AUTO_RESTART_EN
        if (ot_q != '0) ot_d = ot_q - 1'b1;
`endif
        if (press_q) begin
          state_d = S_SERVE;
          timer_d = SD_L;
          serve_d = 1'b1;
          clr_d   = 1'b1;
        end
`ifdef GAME_FLOW_AUTO_RESTART_EN
        else if (ot_q == '0) begin
          state_d = S_IDLE;
          timer_d = '0;
          clr_d   = 1'b1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Moore outputs computed from the next state so they register alongside it
  always_comb begin
    be_d    = (state_d == S_PLAY);
    blink_d = 1'b0;
    if (state_d == S_OVER && state_q == S_OVER)
      blink_d = (timer_q == '0) ? !blink_q : blink_q;
  end

  assign state       = state_q;
  assign ball_enable = be_q;
  assign serve       = serve_q;
  assign serve_dir   = dir_q;
  assign score_clear = clr_q;
  assign blink       = blink_q;

endmodule
